// File: rtl/pow2_term_encoder.sv
// Bit-serial weight encoder: scans a W-bit weight one bit per clock and emits it as
// 2^b_i, 2^b_i + 2^b_j or 2^b_i - 2^b_j for the two-term shift-add multiplier.
module pow2_term_encoder #(
    parameter int N   = 4,
    parameter int a_N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [a_N-1:0] in_a,
    input  logic [(1<<N)-1:0] in_w,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [a_N-1:0] a,
    output logic [N-1:0]   b_i,
    output logic [N-1:0]   b_j,
    output logic           one_term,
    output logic           b_sign,
    output logic           enc_ok
);
    localparam int W = 1 << N;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state_q, state_d;

    logic [N-1:0]   k_q, k_d;
    logic [W-1:0]   w_q, w_d;
    logic [a_N-1:0] acap_q, acap_d;
    logic [N-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [1:0]     pop_q, pop_d;
    logic           seen_q, seen_d, gap_q, gap_d, contig_q, contig_d;

    logic           vld_q, vld_d, one_q, one_d, sign_q, sign_d, ok_q, ok_d;
    logic [a_N-1:0] a_q, a_d;
    logic [N-1:0]   bi_q, bi_d, bj_q, bj_d;

    // stats including the bit under scan, so the last edge can encode from them
    logic [N-1:0] lo_n, hi_n;
    logic [1:0]   pop_n;
    logic         seen_n, gap_n, contig_n;
    logic [N:0]   hi_p1;

    assign in_rdy = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_vld)            state_d = SCAN;
            SCAN:    if (k_q == N'(W - 1))  state_d = DONE;
            DONE:    if (out_rdy)           state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        lo_n     = lo_q;
        hi_n     = hi_q;
        pop_n    = pop_q;
        seen_n   = seen_q;
        gap_n    = gap_q;
        contig_n = contig_q;
        if (w_q[k_q]) begin
            if (!seen_q) lo_n = k_q;
            hi_n   = k_q;
            pop_n  = (pop_q == 2'd3) ? 2'd3 : pop_q + 2'd1;
            seen_n = 1'b1;
            if (gap_q) contig_n = 1'b0;
        end else if (seen_q) begin
            gap_n = 1'b1;
        end
        hi_p1 = {1'b0, hi_n} + (N+1)'(1);
    end

    always_comb begin
        k_d      = k_q;
        w_d      = w_q;
        acap_d   = acap_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        pop_d    = pop_q;
        seen_d   = seen_q;
        gap_d    = gap_q;
        contig_d = contig_q;
        vld_d    = vld_q;
        a_d      = a_q;
        bi_d     = bi_q;
        bj_d     = bj_q;
        one_d    = one_q;
        sign_d   = sign_q;
        ok_d     = ok_q;
        case (state_q)
            IDLE: if (in_vld) begin
                acap_d   = in_a;
                w_d      = in_w;
                k_d      = '0;
                lo_d     = '0;
                hi_d     = '0;
                pop_d    = '0;
                seen_d   = 1'b0;
                gap_d    = 1'b0;
                contig_d = 1'b1;
            end
            SCAN: begin
                k_d      = k_q + N'(1);
                lo_d     = lo_n;
                hi_d     = hi_n;
                pop_d    = pop_n;
                seen_d   = seen_n;
                gap_d    = gap_n;
                contig_d = contig_n;
                if (k_q == N'(W - 1)) begin
                    vld_d  = 1'b1;
                    a_d    = acap_q;
                    one_d  = 1'b0;
                    sign_d = 1'b0;
                    bi_d   = hi_n;
                    bj_d   = lo_n;
                    ok_d   = 1'b0;
                    if (pop_n == 2'd0) begin
                        one_d = 1'b1;
                        bi_d  = '0;
                        bj_d  = '0;
                    end else if (pop_n == 2'd1) begin
                        one_d = 1'b1;
                        bj_d  = '0;
                        ok_d  = 1'b1;
                    end else if (pop_n == 2'd2) begin
                        ok_d  = 1'b1;
                    end else if (contig_n && !hi_p1[N]) begin
                        // a contiguous run lo..hi equals 2^(hi+1) - 2^lo
                        sign_d = 1'b1;
                        bi_d   = hi_p1[N-1:0];
                        ok_d   = 1'b1;
                    end
                end
            end
            DONE: if (out_rdy) vld_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            w_q      <= '0;
            acap_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            pop_q    <= '0;
            seen_q   <= 1'b0;
            gap_q    <= 1'b0;
            contig_q <= 1'b1;
            vld_q    <= 1'b0;
            a_q      <= '0;
            bi_q     <= '0;
            bj_q     <= '0;
            one_q    <= 1'b0;
            sign_q   <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            k_q      <= k_d;
            w_q      <= w_d;
            acap_q   <= acap_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            pop_q    <= pop_d;
            seen_q   <= seen_d;
            gap_q    <= gap_d;
            contig_q <= contig_d;
            vld_q    <= vld_d;
            a_q      <= a_d;
            bi_q     <= bi_d;
            bj_q     <= bj_d;
            one_q    <= one_d;
            sign_q   <= sign_d;
            ok_q     <= ok_d;
        end
    end

    assign out_vld  = vld_q;
    assign a        = a_q;
    assign b_i      = bi_q;
    assign b_j      = bj_q;
    assign one_term = one_q;
    assign b_sign   = sign_q;
    assign enc_ok   = ok_q;
endmodule
